reg_scoreboard: RTL
===================

# reg_scoreboard

Issue-side scoreboard for the in-order RISC-V pipeline. It records which destination registers have results that cannot yet be forwarded, and stalls the ID stage until the forwarding network or register file can supply them. The forwarding unit selects where operands come from. This block tracks results from the writer side and decides when an operand is not yet available anywhere. It sits in ID beside the pipeline-register enable logic and drives the IF/ID hold and ID/EX bubble insertion.

## Interface
- REG_ADDR_W, 5: register index width; 2^REG_ADDR_W entries tracked.
- MAX_LAT, 4: largest accepted result latency in cycles.
- LAT_W, $clog2(MAX_LAT+1): latency field width.
- CNT_W, 16: stall performance counter width.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  valid instruction in ID.
- issue_regwrite  in  1  the instruction writes rd.
- issue_rd  in  REG_ADDR_W  destination register.
- issue_lat  in  LAT_W  cycles until the result becomes forwardable from MEM. ALU is 0, load is 1.
- rs1, rs2  in  REG_ADDR_W  source registers.
- rs1_used, rs2_used  in  1  the source is actually read.
- flush  in  1  ID instruction is squashed this cycle (branch taken).
- stall  out  1  hold IF/ID and inject a bubble into ID/EX.
- busy_vec  out  2^REG_ADDR_W  bit r is set when cnt[r] != 0.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Each register r has a down-counter cnt[r] of LAT_W bits. A value of 0 means the result is available through forwarding or the register file.
- Register x0 is never tracked. cnt[0] is held at 0, and sources or destinations equal to x0 never stall.
- A source hazard exists when rsN_used is high, rsN != 0, and cnt[rsN] != 0.
- stall = issue_valid & !flush & (rs1 hazard | rs2 hazard | WAW hazard). This is combinational from registered state and the current inputs.
- An issue is accepted when issue_valid & !flush & !stall.
- On an accepted issue with issue_regwrite high and issue_rd != 0, cnt[issue_rd] is loaded with min(issue_lat, MAX_LAT).
- Every other nonzero counter decrements by 1 each cycle. Counters saturate at 0.
- If a load and a decrement target the same entry in one cycle, the load wins.
- When flush is high, nothing is loaded and stall is low. Counters still decrement, because older in-flight results remain valid.
- stall_count increments on every cycle where stall is high and saturates at all-ones.
- issue_lat values above MAX_LAT are clamped to MAX_LAT. This is not an error.

## Timing
- Reset values: all cnt = 0, busy_vec = 0, stall = 0 (since it depends only on cnt), stall_count = 0.
- Reset is asynchronous. Asserting it mid-stall clears all entries immediately, and stall falls in the same cycle.
- Suppose an instruction is accepted in cycle T with latency L ≥ 1, and a dependent instruction sits in ID during cycles T+1..T+L.
  - The dependent instruction sees stall = 1 for exactly L cycles.
  - It issues in cycle T+L+1.
- L = 0 never causes a stall, because forwarding covers it.
- busy_vec follows the counters one cycle after the issue edge.
- Back-to-back issues to the same rd: the second load overwrites the first. The larger remaining latency is protected by the WAW check when that check is enabled.

## Configuration
- SCOREBOARD_WAW_CHECK_EN defined:
  - A WAW hazard is flagged when the issue has regwrite high, issue_rd != 0, and cnt[issue_rd] > clamped issue_lat.
  - This stalls until the older write can no longer complete after the younger one.
- SCOREBOARD_WAW_CHECK_EN undefined: the WAW term is constant 0, and the newer load simply overwrites the entry.

## Structure
- Shared package riscv_pipe_pkg holds:
  - REG_ADDR_W and MAX_LAT.
  - The latency constants LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 3.
  - A typedef for lat_t.
- Sub-module sb_lat_counter implements one counter entry. It has inputs load, load_val, and clk/rst_n, and outputs cnt and busy. It is instantiated with a generate loop for entries 1..2^REG_ADDR_W-1.

## Test plan
- Load to x5 with L = 1 in cycle T, then `add x6, x5, x1` in ID at T+1: stall = 1 for 1 cycle, add accepted at T+2, stall_count = 1.
- ALU write to x7 with L = 0, then an immediate consumer of x7: stall never asserts and busy_vec[7] stays 0.
- Write to x0 with L = 3, then a consumer of x0: no stall, and busy_vec = 0.
- Multiply to x9 with L = 3, followed by flush in the next cycle: stall = 0 while flush is high, and cnt[9] still decrements from 3 to 2.
  - The consumer arriving after the flush stalls for the remaining 2 cycles only.
- With SCOREBOARD_WAW_CHECK_EN, a multiply to x3 with L = 3 is followed by an ALU write to x3 with L = 0.
  - Expected: 3 stall cycles, then the ALU write is accepted.
  - Without the macro, the ALU write is accepted at once and cnt[3] = 0.
- rst_n asserted low while cnt[4] = 2 and stall = 1: stall, busy_vec, and stall_count all read 0 before the next clock edge.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
//   Constants shared by the in-order pipeline: register-file addressing,
//   the result latency range tracked by the issue scoreboard, and the
//   per-unit latencies that decode presents on issue_lat.
package riscv_pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int MAX_LAT    = 4;
   localparam int LAT_W      = $clog2(MAX_LAT + 1);

   typedef logic [LAT_W-1:0] lat_t;

   // Cycles until a result can be forwarded from MEM.
   localparam lat_t LAT_ALU  = lat_t'(0);
   localparam lat_t LAT_LOAD = lat_t'(1);
   localparam lat_t LAT_MUL  = lat_t'(3);

endpackage

// File: rtl/sb_lat_counter.sv
// sb_lat_counter
//   One scoreboard entry: a down-counter holding the number of cycles
//   before the pending result for one register becomes forwardable.
//   A load takes priority over the per-cycle decrement; the count
//   stops at zero.
//
// Ports
//   clk       in   pipeline clock
//   rst_n     in   asynchronous active-low reset
//   load      in   load load_val this cycle
//   load_val  in   LAT_W  already-clamped latency
//   cnt       out  LAT_W  current remaining latency
//   busy      out  cnt is nonzero
module sb_lat_counter #(
   parameter int LAT_W = riscv_pipe_pkg::LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             busy
);

   logic [LAT_W-1:0] cnt_q;
   logic [LAT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - LAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign busy = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-side scoreboard for the in-order pipeline. Tracks, per
//   destination register, how many cycles remain before its result can
//   be forwarded, and stalls ID while any used source (or, optionally,
//   an older longer-latency write to the same rd) is still pending.
//
// Build option
//   SCOREBOARD_WAW_CHECK_EN  when defined, an issue whose rd still has a
//                            pending write that would complete after the
//                            new one is stalled (WAW hazard).
//
// Ports
//   clk             in   pipeline clock
//   rst_n           in   asynchronous active-low reset
//   issue_valid     in   valid instruction in ID
//   issue_regwrite  in   instruction writes rd
//   issue_rd        in   REG_ADDR_W  destination register
//   issue_lat       in   LAT_W       result latency (clamped to MAX_LAT)
//   rs1, rs2        in   REG_ADDR_W  source registers
//   rs1_used        in   rs1 is read
//   rs2_used        in   rs2 is read
//   flush           in   ID instruction squashed this cycle
//   stall           out  hold IF/ID, bubble into ID/EX
//   busy_vec        out  2^REG_ADDR_W  per-register pending flags
//   stall_count     out  CNT_W  saturating count of stalled cycles
module reg_scoreboard #(
   parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
   parameter int MAX_LAT    = riscv_pipe_pkg::MAX_LAT,
   parameter int LAT_W      = $clog2(MAX_LAT + 1),
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       issue_valid,
   input  logic                       issue_regwrite,
   input  logic [REG_ADDR_W-1:0]      issue_rd,
   input  logic [LAT_W-1:0]           issue_lat,
   input  logic [REG_ADDR_W-1:0]      rs1,
   input  logic [REG_ADDR_W-1:0]      rs2,
   input  logic                       rs1_used,
   input  logic                       rs2_used,
   input  logic                       flush,
   output logic                       stall,
   output logic [(1<<REG_ADDR_W)-1:0] busy_vec,
   output logic [CNT_W-1:0]           stall_count
);

   import riscv_pipe_pkg::*;

   localparam int NREG = 1 << REG_ADDR_W;

   function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
      if (lat > LAT_W'(MAX_LAT)) begin
         return LAT_W'(MAX_LAT);
      end
      return lat;
   endfunction

   logic [NREG-1:0][LAT_W-1:0] ent_cnt;
   logic [LAT_W-1:0]           lat_clamped;
   logic                       rs1_haz;
   logic                       rs2_haz;
   logic                       waw_haz;
   logic                       issue_ok;
   logic [CNT_W-1:0]           stall_count_q;
   logic [CNT_W-1:0]           stall_count_d;

   assign lat_clamped = clamp_lat(issue_lat);

   // x0 is hardwired: its entry always reads as available.
   assign ent_cnt[0]  = '0;
   assign busy_vec[0] = 1'b0;

   assign rs1_haz = rs1_used && (rs1 != '0) && (ent_cnt[rs1] != '0);
   assign rs2_haz = rs2_used && (rs2 != '0) && (ent_cnt[rs2] != '0);

`ifdef SCOREBOARD_WAW_CHECK_EN
   // Hold the younger write until the older one can no longer land after it.
   assign waw_haz = issue_regwrite && (issue_rd != '0) &&
                    (ent_cnt[issue_rd] > lat_clamped);
`else
   assign waw_haz = 1'b0;
`endif

   // A squashed instruction never stalls and never claims its rd.
   assign stall    = issue_valid && !flush && (rs1_haz || rs2_haz || waw_haz);
   assign issue_ok = issue_valid && !flush && !stall;

   for (genvar i = 1; i < NREG; i++) begin : g_entry
      sb_lat_counter #(
         .LAT_W (LAT_W)
      ) u_cnt (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (issue_ok && issue_regwrite && (issue_rd == REG_ADDR_W'(i))),
         .load_val (lat_clamped),
         .cnt      (ent_cnt[i]),
         .busy     (busy_vec[i])
      );
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && !(&stall_count_q)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule
